lane_array_collector: RTL and testbench



---
 rtl/lane_array_collector.sv | 139 +++++++++++++
 tb/tb_lane_array_collector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_array_collector.sv
// Gathers single-lane words into an N-lane array; output registered one edge after the completing word.
// Backpressure: a completed frame that finds the output occupied parks in the collect buffer and drops s_ready until taken.
module lane_array_collector #(
    parameter int TEST = 6,
    parameter int CW   = $clog2(TEST + 3)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [TEST+1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [TEST+1:0]       m_array [TEST+2],
    output logic [CW-1:0]         m_count,
    output logic                  m_trunc
);

    localparam int N  = TEST + 2;
    localparam int W  = TEST + 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    lane_q  [N];
    logic [W-1:0]    lane_d  [N];
    logic [W-1:0]    out_q   [N];
    logic [W-1:0]    out_d   [N];
    logic [W-1:0]    frame   [N];
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   hcnt_q, hcnt_d;
    logic            htrunc_q, htrunc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            trunc_q, trunc_d;
    logic            vld_q, vld_d;

    logic            accept;
    logic            take;
    logic            out_free;
    logic            last_lane;
    logic [CW-1:0]   fcnt;
    logic            ftrunc;

    assign s_ready   = (state_q == COLLECT);
    assign accept    = s_valid && s_ready;
    assign take      = vld_q && m_ready;
    assign out_free  = !vld_q || m_ready;
    assign last_lane = (idx_q == IW'(N - 1));
    assign fcnt      = CW'(idx_q) + CW'(1);
    assign ftrunc    = last_lane && !s_last;

    assign m_valid = vld_q;
    assign m_array = out_q;
    assign m_count = cnt_q;
    assign m_trunc = trunc_q;

    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        idx_d    = idx_q;
        hcnt_d   = hcnt_q;
        htrunc_d = htrunc_q;
        out_d    = out_q;
        cnt_d    = cnt_q;
        trunc_d  = trunc_q;
        vld_d    = vld_q && !m_ready;
        frame    = lane_q;
        if (accept) begin
            frame[idx_q] = s_data;
        end

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (s_last || last_lane) begin
                        idx_d = '0;
                        if (out_free) begin
                            out_d   = frame;
                            cnt_d   = fcnt;
                            trunc_d = ftrunc;
                            vld_d   = 1'b1;
                            lane_d  = '{default: '0};
                        end else begin
                            // Output still owned downstream: park the finished frame in place.
                            lane_d   = frame;
                            hcnt_d   = fcnt;
                            htrunc_d = ftrunc;
                            state_d  = HOLD;
                        end
                    end else begin
                        lane_d = frame;
                        idx_d  = idx_q + IW'(1);
                    end
                end
            end
            HOLD: begin
                if (take) begin
                    out_d   = lane_q;
                    cnt_d   = hcnt_q;
                    trunc_d = htrunc_q;
                    vld_d   = 1'b1;
                    lane_d  = '{default: '0};
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= COLLECT;
            lane_q   <= '{default: '0};
            idx_q    <= '0;
            hcnt_q   <= '0;
            htrunc_q <= 1'b0;
            out_q    <= '{default: '0};
            cnt_q    <= '0;
            trunc_q  <= 1'b0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            idx_q    <= idx_d;
            hcnt_q   <= hcnt_d;
            htrunc_q <= htrunc_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
            trunc_q  <= trunc_d;
            vld_q    <= vld_d;
        end
    end

endmodule

// File: tb/tb_lane_array_collector.sv
// Randomized and directed stimulus against a frame-level reference model; a monitor scores every output handshake.
module tb_lane_array_collector;

    localparam int TEST = 6;
    localparam int N    = TEST + 2;
    localparam int CW   = $clog2(TEST + 3);

    typedef struct packed {
        logic [N-1:0][7:0] lanes;
        logic [CW-1:0]     cnt;
        logic              trunc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          s_last;
    logic          m_valid;
    logic          m_ready;
    logic [7:0]    m_array [N];
    logic [CW-1:0] m_count;
    logic          m_trunc;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    logic [7:0] cur[$];
    bit   rdy_rand = 1'b0;
    int   run_len  = 0;
    int   max_run  = 0;

    lane_array_collector #(.TEST(TEST)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_array (m_array),
        .m_count (m_count),
        .m_trunc (m_trunc)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic logic [N-1:0][7:0] pack_out();
        logic [N-1:0][7:0] p;
        for (int i = 0; i < N; i++) p[i] = m_array[i];
        return p;
    endfunction

    // Reference model: a frame is the list of accepted words, closed by s_last or by reaching N words.
    function automatic void model_accept(logic [7:0] d, logic last);
        exp_t e;
        cur.push_back(d);
        if (last || cur.size() == N) begin
            e.lanes = '0;
            for (int i = 0; i < cur.size(); i++) e.lanes[i] = cur[i];
            e.cnt   = CW'(cur.size());
            e.trunc = (cur.size() == N) && !last;
            exp_q.push_back(e);
            cur.delete();
        end
    endfunction

    // Monitor: scores each handshake and checks outputs hold steady under stall.
    initial begin
        exp_t e;
        bit   prev_stall = 1'b0;
        exp_t prev;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                run_len    = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_array", 64'(pack_out()), 64'(prev.lanes));
                    chk("stall_count", 64'(m_count), 64'(prev.cnt));
                    chk("stall_trunc", 64'(m_trunc), 64'(prev.trunc));
                end
                if (m_valid && m_ready) begin
                    chk("out_expected", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_array", 64'(pack_out()), 64'(e.lanes));
                        chk("out_count", 64'(m_count), 64'(e.cnt));
                        chk("out_trunc", 64'(m_trunc), 64'(e.trunc));
                    end
                end
                run_len    = m_valid ? run_len + 1 : 0;
                if (run_len > max_run) max_run = run_len;
                prev_stall = m_valid && !m_ready;
                prev.lanes = pack_out();
                prev.cnt   = m_count;
                prev.trunc = m_trunc;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) m_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at posedge+1; returns at posedge+1 after the word was accepted.
    task automatic send(input logic [7:0] d, input logic last);
        int waited = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(d, last);
                @(posedge clk);
                #1;
                break;
            end
            waited++;
            if (waited > 500) begin
                chk("send_timeout", 64'(0), 64'(1));
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !m_valid) break;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_valid", 64'(m_valid), 64'(0));
        chk("rst_m_count", 64'(m_count), 64'(0));
        chk("rst_m_trunc", 64'(m_trunc), 64'(0));
        chk("rst_m_array", 64'(pack_out()), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'(1));

        // Full frame
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(8'h10 + 8'(i), i == N - 1);
        chk("t1_latency", 64'(m_valid), 64'(1));
        wait_idle();

        // Short frame
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        send(8'hA3, 1'b1);
        wait_idle();

        // Truncation, then close the spill-over frame
        for (int i = 0; i < 10; i++) send(8'(i), 1'b0);
        send(8'h0A, 1'b1);
        wait_idle();

        // Backpressure: two full frames against a stalled output
        m_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(8'h20 + 8'(i), (i % N) == N - 1);
        @(negedge clk);
        chk("t4_s_ready_low", 64'(s_ready), 64'(0));
        chk("t4_m_valid", 64'(m_valid), 64'(1));
        chk("t4_first_lane0", 64'(m_array[0]), 64'(8'h20));
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        chk("t4_release_valid", 64'(m_valid), 64'(1));
        chk("t4_release_ready", 64'(s_ready), 64'(1));
        chk("t4_second_lane0", 64'(m_array[0]), 64'(8'h28));
        repeat (3) @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_idle();

        // Streaming single-word frames
        max_run = 0;
        for (int i = 0; i < N; i++) send(8'h50 + 8'(i), 1'b1);
        wait_idle();
        chk("t5_valid_run", 64'(max_run), 64'(N));

        // Reset mid-frame
        for (int i = 0; i < 4; i++) send(8'h60 + 8'(i), 1'b0);
        rst_n = 1'b0;
        cur.delete();
        exp_q.delete();
        #1;
        chk("t6_rst_valid", 64'(m_valid), 64'(0));
        chk("t6_rst_count", 64'(m_count), 64'(0));
        chk("t6_rst_array", 64'(pack_out()), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h70, 1'b0);
        send(8'h71, 1'b1);
        wait_idle();

        // Randomized traffic with random downstream stalls
        rdy_rand = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            send(8'($urandom), $urandom_range(0, 4) == 0);
        end
        send(8'hEE, 1'b1);
        rdy_rand = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
